// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// One-bit full adder; the combinational slice reused by serial_adder every bit time.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: {c,s} = a + b + cin, one bit per clock, LSB first.
// state | meaning:  IDLE | waiting for start,  RUN | shifting one bit per edge,  DONE | result valid (done=1)
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             shift;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .a   (op_a[0]),
        .b   (op_b[0]),
        .cin (carry),
        .s   (fa_s),
        .c   (fa_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                shift = 1'b1;
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at s[0].
    always_comb begin
        sum_next            = sum_reg >> 1;
        sum_next[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            carry   <= 1'b0;
            sum_reg <= '0;
            cnt     <= '0;
        end else if (load) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (shift) begin
            op_a    <= op_a >> 1;
            op_b    <= op_b >> 1;
            carry   <= fa_c;
            sum_reg <= sum_next;
            if (cnt != LAST) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign s = sum_reg;
    assign c = carry;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=8 and WIDTH=1 against a plain arithmetic model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] s8;
    logic       c8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] s1;
    logic       c1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .s     (s8),
        .c     (c8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .s     (s1),
        .c     (c1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full 8-bit transaction: busy for 8 cycles, then one done cycle carrying a+b+cin.
    task automatic add8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input string tag);
        logic [8:0] exp;
        exp    = 9'(ta) + 9'(tb_) + 9'(tc);
        start8 = 1'b1;
        a8     = ta;
        b8     = tb_;
        cin8   = tc;
        tick();
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        cin8   = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s busy/done cyc%0d", tag, i), {30'd0, busy8, done8}, 32'b10);
            tick();
        end
        check({tag, " done"}, {30'd0, busy8, done8}, 32'b01);
        check({tag, " sum"}, {23'd0, c8, s8}, {23'd0, exp});
        tick();
        check({tag, " done drop"}, {30'd0, busy8, done8}, 32'b00);
    endtask

    task automatic add1(input logic ta, input logic tb_, input logic tc);
        logic [1:0] exp;
        string      tag;
        exp    = 2'(ta) + 2'(tb_) + 2'(tc);
        tag    = $sformatf("w1 %0d%0d%0d", ta, tb_, tc);
        start1 = 1'b1;
        a1     = ta;
        b1     = tb_;
        cin1   = tc;
        tick();
        start1 = 1'b0;
        check({tag, " run"}, {30'd0, busy1, done1}, 32'b10);
        tick();
        check({tag, " done"}, {30'd0, busy1, done1}, 32'b01);
        check({tag, " sum"}, {30'd0, c1, s1}, {30'd0, exp});
        tick();
        check({tag, " idle"}, {30'd0, busy1, done1}, 32'b00);
    endtask

    initial begin
        logic       no_done;
        logic [8:0] held;

        rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset w8", {22'd0, busy8, done8, c8, s8}, 32'd0);
        check("reset w1", {28'd0, busy1, done1, c1, s1}, 32'd0);

        add8(8'h00, 8'h00, 1'b0, "zero");
        add8(8'hFF, 8'h01, 1'b0, "ff+01");
        add8(8'h7F, 8'h01, 1'b0, "7f+01");
        add8(8'hA5, 8'h5A, 1'b1, "a5+5a+1");

        held = {c8, s8};
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold idle%0d", i), {21'd0, busy8, done8, c8, s8}, {21'd0, 2'b00, held});
        end

        // Second start while running must be ignored.
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("ignore start done", {30'd0, busy8, done8}, 32'b01);
        check("ignore start sum", {23'd0, c8, s8}, 32'h046);
        tick();

        // Abort mid-RUN with a nonzero partial sum and carry.
        start8 = 1'b1; a8 = 8'h0F; b8 = 8'h0F; cin8 = 1'b0;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort state", {22'd0, busy8, done8, c8, s8}, 32'd0);
        no_done = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 !== 1'b0 || busy8 !== 1'b0) no_done = 1'b0;
        end
        check("abort no done", {31'd0, no_done}, 32'd1);
        add8(8'h03, 8'h04, 1'b0, "after abort");

        // Reset wins over start on the same edge.
        rst = 1'b1; start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        tick();
        rst = 1'b0; start8 = 1'b0;
        check("rst over start", {22'd0, busy8, done8, c8, s8}, 32'd0);
        tick();
        check("rst over start idle", {30'd0, busy8, done8}, 32'b00);

        for (int i = 0; i < 24; i++) begin
            add8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            add1(v[2], v[1], v[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits; legal range 1..32.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start  input  1  request to load operands and begin an addition.
REQ-005 SHALL have port a  input  WIDTH  first operand, sampled only on an accepted start.
REQ-006 SHALL have port b  input  WIDTH  second operand, sampled only on an accepted start.
REQ-007 SHALL have port cin  input  1  carry-in, sampled only on an accepted start.
REQ-008 SHALL have port busy  output  1  high while bits are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking that the result is valid.
REQ-010 SHALL have port s  output  WIDTH  sum result.
REQ-011 SHALL have port c  output  1  carry-out result.

Function
REQ-012 SHALL use three states: IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE; at that edge:
- latch a and b into shift registers and cin into the carry flop;
- clear the bit counter;
- go to RUN.
REQ-014 SHALL ignore start in RUN and DONE: no reload, and the result is not disturbed.
REQ-015 SHALL process exactly one bit per RUN edge, LSB first:
- sum bit = a_lsb XOR b_lsb XOR carry;
- new carry = majority(a_lsb, b_lsb, carry);
- the sum bit shifts into the MSB of the result register;
- both operand registers shift right.
REQ-016 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1; with start accepted at edge k, that edge is k+WIDTH.
REQ-017 SHALL drive done=1 for exactly the one cycle spent in DONE, then return to IDLE at the next edge.
REQ-018 SHALL drive busy=1 exactly when in RUN, i.e. for WIDTH cycles per addition.
REQ-019 SHALL drive s and c from registers, not combinationally:
- s is valid when done rises; c equals the final carry;
- s and c hold their values through IDLE until the next accepted start;
- s and c may change during RUN.
REQ-020 SHALL produce the mathematical result {c,s} = a + b + cin, with a WIDTH+1-bit result and no truncation of the carry.
REQ-021 SHALL accept start asserted in the IDLE cycle right after DONE, allowing back-to-back operations at WIDTH+2 cycles per addition.
REQ-022 SHALL give the counter ceil(log2(WIDTH)) bits, minimum 1, with no wrap beyond WIDTH-1.
REQ-023 SHALL, for WIDTH=1, spend one RUN cycle and give a result equal to the existing full-adder truth table.

Reset
REQ-024 SHALL, when rst=1 at an edge, take this reset state regardless of state or start:
- state=IDLE, busy=0, done=0, s=0, c=0;
- counter=0, operand registers=0, carry=0.
REQ-025 SHALL abort an addition if rst arrives mid-RUN: no done pulse, and the partial sum is discarded (s=0).
REQ-026 SHALL give rst priority over start when both are high on the same edge.

Structure
REQ-027 SHALL place the state encoding (IDLE, RUN, DONE) in shared package adder_pkg, together with the default WIDTH constant.
REQ-028 SHALL compute the per-bit sum and carry with one instance of the existing full_adder sub-module (ports a, b, cin, s, c).
REQ-029 SHALL contain all sequential logic in serial_adder; full_adder remains purely combinational.

Verification
REQ-030 SHALL cover: WIDTH=8, a=0x00, b=0x00, cin=0, start at edge k -> busy high for 8 cycles; done only in the cycle after edge k+8; s=0x00, c=0.
REQ-031 SHALL cover: a=0xFF, b=0x01, cin=0 -> s=0x00, c=1; and a=0x7F, b=0x01, cin=0 -> s=0x80, c=0.
REQ-032 SHALL cover: a=0xA5, b=0x5A, cin=1 -> s=0x00, c=1; s and c hold for 5 idle cycles afterwards.
REQ-033 SHALL cover: start with a=0x12, b=0x34, then start again mid-RUN with a=0xFF, b=0xFF -> ignored; s=0x46, c=0.
REQ-034 SHALL cover: rst pulsed at RUN cycle 4 -> next cycle busy=0, done=0, s=0x00, c=0; no done pulse follows; a fresh start (0x03+0x04) gives s=0x07.
REQ-035 SHALL cover: WIDTH=1, all 8 combinations of a, b, cin -> {c,s} matches the full-adder truth table; done two edges after start.
